// File: rtl/jt49_cen_multi_if.sv
// Control/enable bundle for jt49_cen_multi: base-enable inputs and
// pre-divider controls in one direction, the generated enables in the other.
interface jt49_cen_multi_if #(
    parameter int NOUT = 2,
    parameter int FW   = 16
);
    logic            cen;
    logic            use_frac;
    logic [FW-1:0]   num;
    logic [FW-1:0]   den;
    logic            sel;
    logic            restart;
    logic            cen_base;
    logic [NOUT-1:0] cen_out;

    modport master (
        output cen, use_frac, num, den, sel, restart,
        input  cen_base, cen_out
    );

    modport slave (
        input  cen, use_frac, num, den, sel, restart,
        output cen_base, cen_out
    );
endinterface

// File: rtl/jt49_cen_multi.sv
// Clock-enable generator for the PSG: optional num/den fractional pre-divider
// feeding a shared counter that yields NOUT power-of-two sub-rate enables.

// One tap: decides whether the current base pulse lands on this tap's phase.
module jt49_cen_tap #(
    parameter int W  = 10,
    parameter int TK = 4
) (
    input  logic [W-1:0] i_cnt,
    input  logic         i_sel,
    output logic         o_hit
);
    localparam logic [W:0] ONE    = (W+1)'(1);
    localparam logic [W:0] M_FAST = (ONE << TK) - ONE;
    localparam logic [W:0] M_SLOW = (ONE << (TK + 1)) - ONE;

    logic [W-1:0] w_mask;

    // sel=0 widens the mask by one bit, i.e. one extra /2 on the tap
    assign w_mask = i_sel ? M_FAST[W-1:0] : M_SLOW[W-1:0];
    assign o_hit  = ((i_cnt & w_mask) == '0);
endmodule

module jt49_cen_multi #(
    parameter int                W    = 10,
    parameter int                NOUT = 2,
    parameter logic [4*NOUT-1:0] TAPS = {4'd8, 4'd4},
    parameter int                FW   = 16
) (
    input logic              clk,
    input logic              rst_n,
    jt49_cen_multi_if.slave  bus
);
    logic [FW:0]     r_acc;
    logic [W-1:0]    r_cnt;
    logic            r_cen_base;
    logic [NOUT-1:0] r_cen_out;

    logic [FW+1:0]   w_sum;
    logic [FW:0]     w_acc_nxt;
    logic            w_b;
    logic [NOUT-1:0] w_hit;

    assign w_sum = {1'b0, r_acc} + {2'b00, bus.num};

    // Fractional pre-divider; a degenerate ratio (den==0 or num>=den) parks
    // the accumulator at zero so a later valid ratio starts clean.
    always_comb begin
        w_b       = bus.cen;
        w_acc_nxt = r_acc;
        if (bus.use_frac) begin
            if (bus.den == '0) begin
                w_b       = 1'b0;
                w_acc_nxt = '0;
            end else if (bus.num >= bus.den) begin
                w_b       = bus.cen;
                w_acc_nxt = '0;
            end else if (bus.cen) begin
                if (w_sum >= {2'b00, bus.den}) begin
                    w_b       = 1'b1;
                    w_acc_nxt = w_sum[FW:0] - {1'b0, bus.den};
                end else begin
                    w_b       = 1'b0;
                    w_acc_nxt = w_sum[FW:0];
                end
            end else begin
                w_b = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NOUT; i++) begin : g_tap
        jt49_cen_tap #(
            .W  (W),
            .TK (int'(TAPS[4*i +: 4]))
        ) u_tap (
            .i_cnt (r_cnt),
            .i_sel (bus.sel),
            .o_hit (w_hit[i])
        );
    end

    // Taps look at the pre-increment count, so the first base pulse after a
    // clear lines every tap up on phase zero.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.restart) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_cen_base <= 1'b0;
            r_cen_out  <= '0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_cen_base <= w_b;
            r_cen_out  <= w_hit & {NOUT{w_b}};
            if (w_b) r_cnt <= r_cnt + W'(1);
        end
    end

    assign bus.cen_base = r_cen_base;
    assign bus.cen_out  = r_cen_out;
endmodule
